mem_bridge: RTL and testbench
=============================

Name: mem_bridge

Overview:
Byte-wide memory bus bridge between the multicycle controller/datapath and an external variable-latency memory. It converts the controller's level memread/memwrite strobes into a req/ack bus transaction. It stalls the controller with busy until the transaction completes. It latches read data for the instruction register and the data register, and flags hung transactions with a timeout error.

Parameters:
AW, 8, address width (bits)
DW, 8, data width (bits)
TIMEOUT, 15, max cycles in REQ without m_ack before abort (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
memread  in  1  read request level from controller
memwrite  in  1  write request level from controller
adr  in  AW  byte address from datapath (PC or ALUOut per iord)
wd  in  DW  write data from datapath
rd  out  DW  registered read data, valid from DONE onward
busy  out  1  stall to controller; controller holds state/outputs while high
done  out  1  one-cycle completion pulse
err  out  1  one-cycle timeout pulse (coincident with done)
m_req  out  1  bus request, registered
m_we  out  1  bus write enable, registered
m_adr  out  AW  bus address, registered
m_wdata  out  DW  bus write data, registered
m_rdata  in  DW  bus read data, valid with m_ack
m_ack  in  1  bus acknowledge, single cycle

Behaviour:
- Reset (rst=0, async): state IDLE; rd=0, m_req=0, m_we=0, m_adr=0, m_wdata=0, timer=0. The done and err registers are 0. busy=0 while rst low.
- States: IDLE, REQ, DONE (2-bit encoding).
- IDLE: on memread|memwrite, capture adr/wd into m_adr/m_wdata and set m_we=memwrite. Set m_req=1 and go to REQ. memwrite has priority if both are high; the transaction is then a write and no error is raised.
- REQ: m_req held 1, timer increments each cycle.
  - m_ack=1: rd<=m_rdata (read only; rd unchanged on write). m_req<=0, go to DONE, done=1.
  - timer reaches TIMEOUT-1 with no ack: m_req<=0, rd<=0 (read only), go to DONE with done=1 and err=1.
  - m_ack in the same cycle as expiry: ack wins, no err.
- DONE: done/err high for exactly this cycle. Requests are ignored, because the controller is still showing the same request. Unconditional return to IDLE; timer cleared.
- busy (combinational) = (state==IDLE & (memread|memwrite)) | (state==REQ). busy is low in DONE, so the controller advances on the DONE edge.
- Latency: request seen at cycle t in IDLE. With ack in REQ cycle t+k (k>=1), DONE is at t+k+1 and rd is valid from t+k+1. Minimum stall is 2 cycles.
- m_ack while in IDLE or DONE: ignored, no state change.
- Back-to-back requests: the next request is accepted in IDLE at the cycle after DONE. There is no pipelining; one outstanding transaction at a time.
- Reset mid-REQ: m_req drops immediately (async), and the transaction is abandoned without done.
- Timer is a $clog2(TIMEOUT+1)-bit counter and never wraps; it saturates at expiry.
- All bus outputs are registered; no combinational path from memread/memwrite to m_req.

Decomposition:
- mem_bridge_pkg: state encodings (IDLE=2'b00, REQ=2'b01, DONE=2'b10), default TIMEOUT, AW/DW defaults.
- Sub-module wait_timer: clear/enable/expire counter parameterised by TIMEOUT. It has clk, rst, clr, en inputs and an expired output.

Test Plan:
- Reset: rst=0 mid-REQ with m_req=1 -> m_req=0 and busy=0 within the same cycle; rd=0; state IDLE after release.
- Read, ack after 3 REQ cycles: memread=1, adr=8'h10, m_rdata=8'hA5 -> m_req high 3 cycles with m_adr=8'h10 and m_we=0. Then done=1 for 1 cycle, rd=8'hA5, err=0, busy low in the DONE cycle.
- Write with immediate ack: memwrite=1, adr=8'h20, wd=8'h3C, m_ack in first REQ cycle -> m_we=1, m_wdata=8'h3C, done at t+2, rd unchanged.
- Timeout: memread=1 with m_ack never asserted, TIMEOUT=15 -> m_req high 15 cycles, then done=1 and err=1 together, rd=8'h00.
- Ack coincident with expiry: m_ack=1 in the 15th REQ cycle, m_rdata=8'h77 -> rd=8'h77, err=0.
- Fetch sequence: four consecutive memread requests at adr 0..3 returning 8'h20,8'h02,8'h00,8'h05 -> four transactions with one IDLE gap each, and no double-issue while memread is still high in DONE. Also: memread&memwrite together -> write transaction; stray m_ack in IDLE -> no effect.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// Shared encodings and default sizing for the memory bus bridge.
package mem_bridge_pkg;

  localparam int unsigned AW_DEF      = 8;
  localparam int unsigned DW_DEF      = 8;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mem_bridge_wait_timer.sv
// Saturating wait counter; expired is high while the count sits at TIMEOUT-1.
module wait_timer
  import mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt;

  // Count while enabled; expired is kept as a flag so it needs no decode downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      expired <= (LAST == '0);
    end else if (clr) begin
      cnt     <= '0;
      expired <= (LAST == '0);
    end else if (en && !expired) begin
      cnt     <= cnt + TW'(1);
      expired <= ((cnt + TW'(1)) == LAST);
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// Converts controller memread/memwrite levels into a single req/ack bus transaction.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rd,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_adr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack
);

  state_t state;
  logic   expired;

  // Timer runs only during REQ and is held at zero otherwise.
  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != ST_REQ),
    .en      (state == ST_REQ),
    .expired (expired)
  );

  // Stall the controller from the request cycle until DONE; forced low in reset.
  assign busy = rst & (((state == ST_IDLE) & (memread | memwrite)) | (state == ST_REQ));

  // Transaction sequencer with registered bus and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      rd      <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_adr   <= '0;
      m_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (memread || memwrite) begin
            m_adr   <= adr;
            m_wdata <= wd;
            m_we    <= memwrite;
            m_req   <= 1'b1;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (m_ack) begin
            if (!m_we) rd <= m_rdata;
            m_req <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (expired) begin
            if (!m_we) rd <= '0;
            m_req <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
            state <= ST_DONE;
          end
        end
        // The controller still shows the finished request here, so it is ignored.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed scoreboard bench for mem_bridge.
module tb_mem_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       memread, memwrite;
  logic [7:0] adr, wd;
  logic [7:0] rd;
  logic       busy, done, err;
  logic       m_req, m_we;
  logic [7:0] m_adr, m_wdata, m_rdata;
  logic       m_ack;

  typedef struct packed {
    logic [7:0] rd;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_bridge dut (
    .clk     (clk),
    .rst     (rst),
    .memread (memread),
    .memwrite(memwrite),
    .adr     (adr),
    .wd      (wd),
    .rd      (rd),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_adr   (m_adr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected response.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard expected none");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_rd", 32'(rd), 32'(e.rd));
        chk("done_err", 32'(err), 32'(e.err));
      end
    end
  end

  // Issue one transaction from an IDLE negedge; ack_at is the REQ cycle carrying m_ack (0 = never).
  task automatic do_txn(input logic rdq, input logic wrq, input logic [7:0] a,
                        input logic [7:0] w, input logic [7:0] rdata, input int ack_at,
                        input logic [7:0] exp_rd, input logic exp_err, input int exp_cycles);
    int  count;
    bit  seen;
    exp_t e;
    e.rd  = exp_rd;
    e.err = exp_err;
    exp_q.push_back(e);
    memread  = rdq;
    memwrite = wrq;
    adr      = a;
    wd       = w;
    m_ack    = 1'b0;
    #1;
    chk("busy_on_request", 32'(busy), 32'd1);
    count = 0;
    seen  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (m_req === 1'b1) begin
        count++;
        if (count == 1) begin
          chk("m_adr", 32'(m_adr), 32'(a));
          chk("m_we", 32'(m_we), 32'(wrq));
          if (wrq) chk("m_wdata", 32'(m_wdata), 32'(w));
        end
        m_ack   = (count == ack_at);
        m_rdata = (count == ack_at) ? rdata : 8'hEE;
      end else begin
        m_ack = 1'b0;
      end
    end
    m_ack = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: got no done within 40 cycles expected done");
    end else begin
      chk("req_cycles", 32'(count), 32'(exp_cycles));
      chk("busy_in_done", 32'(busy), 32'd0);
      chk("m_req_in_done", 32'(m_req), 32'd0);
    end
    // Request is still held through DONE; the next cycle must be IDLE with no reissue.
    @(negedge clk);
    chk("no_double_issue", 32'(m_req), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    rst      = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    adr      = 8'h00;
    wd       = 8'h00;
    m_rdata  = 8'h00;
    m_ack    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_m_adr", 32'(m_adr), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Read acked in the third REQ cycle.
    do_txn(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 3, 8'hA5, 1'b0, 3);
    // Write acked immediately; rd keeps the previous read value.
    do_txn(1'b0, 1'b1, 8'h20, 8'h3C, 8'h5A, 1, 8'hA5, 1'b0, 1);
    // Timeout: no ack, fifteen REQ cycles, rd cleared.
    do_txn(1'b1, 1'b0, 8'h30, 8'h00, 8'h00, 0, 8'h00, 1'b1, 15);
    // Ack on the expiry cycle wins.
    do_txn(1'b1, 1'b0, 8'h31, 8'h00, 8'h77, 15, 8'h77, 1'b0, 15);
    // Back-to-back fetch sequence.
    do_txn(1'b1, 1'b0, 8'h00, 8'h00, 8'h20, 1, 8'h20, 1'b0, 1);
    do_txn(1'b1, 1'b0, 8'h01, 8'h00, 8'h02, 2, 8'h02, 1'b0, 2);
    do_txn(1'b1, 1'b0, 8'h02, 8'h00, 8'h00, 1, 8'h00, 1'b0, 1);
    do_txn(1'b1, 1'b0, 8'h03, 8'h00, 8'h05, 2, 8'h05, 1'b0, 2);
    // Read and write together behave as a write.
    do_txn(1'b1, 1'b1, 8'h40, 8'hC3, 8'h11, 2, 8'h05, 1'b0, 2);

    // Stray ack in IDLE.
    memread  = 1'b0;
    memwrite = 1'b0;
    m_ack    = 1'b1;
    m_rdata  = 8'h99;
    @(negedge clk);
    m_ack = 1'b0;
    chk("stray_ack_m_req", 32'(m_req), 32'd0);
    chk("stray_ack_rd", 32'(rd), 32'h05);
    chk("stray_ack_busy", 32'(busy), 32'd0);
    chk("stray_ack_done", 32'(done), 32'd0);

    // Reset in the middle of a REQ abandons the transaction.
    memread = 1'b1;
    adr     = 8'h50;
    @(negedge clk);
    chk("pre_reset_m_req", 32'(m_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midreset_m_req", 32'(m_req), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_rd", 32'(rd), 32'd0);
    memread = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_m_req", 32'(m_req), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
